// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and twiddle rounding helper for the FFT datapath.
package fft_pkg;

  localparam int unsigned N_DEF   = 64;
  localparam int unsigned DW_DEF  = 16;
  localparam int unsigned TW_FRAC = 8;
  localparam int unsigned LOG2N   = $clog2(N_DEF);

  localparam real PI       = 3.14159265358979323846;
  localparam real TW_SCALE = real'(32'd1 << TW_FRAC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Round half away from zero, the rounding used for the twiddle table.
  function automatic int round_q(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(0.5 - x);
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// N/2-entry twiddle table, Q(DW-9).8, built at elaboration; one-cycle registered read.
module twiddle_rom
  import fft_pkg::*;
#(
  parameter int unsigned N    = N_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter bit          CONJ = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [$clog2(N)-2:0]   addr,
  output logic [DW-1:0]          w_r,
  output logic [DW-1:0]          w_i
);

  localparam int unsigned DEPTH = N / 2;

  logic [DW-1:0] rom_r [DEPTH];
  logic [DW-1:0] rom_i [DEPTH];

  // CONJ flips the sign of the imaginary part for inverse-transform twiddles.
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam real ANG = 2.0 * PI * real'(g) / real'(N);
    assign rom_r[g] = DW'(round_q(TW_SCALE * $cos(ANG)));
    assign rom_i[g] = CONJ ? DW'(round_q(TW_SCALE * $sin(ANG)))
                           : DW'(-round_q(TW_SCALE * $sin(ANG)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_r <= '0;
      w_i <= '0;
    end else if (en) begin
      w_r <= rom_r[addr];
      w_i <= rom_i[addr];
    end
  end

endmodule

// File: rtl/twiddle_sequencer.sv
// Frames one radix-2 DIF transform and pairs each butterfly difference with its twiddle.
// Build option: define TWIDDLE_CONJ_EN for conjugate (inverse FFT) twiddles on w_i.
module twiddle_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_re,
  input  logic [DW-1:0]          in_im,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_re,
  output logic [DW-1:0]          out_im,
  output logic [DW-1:0]          w_r,
  output logic [DW-1:0]          w_i,
  output logic [$clog2(N)-1:0]   stage_idx,
  output logic                   last,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned LW = $clog2(N);
  localparam int unsigned KW = LW - 1;

`ifdef TWIDDLE_CONJ_EN
  localparam bit CONJ = 1'b1;
`else
  localparam bit CONJ = 1'b0;
`endif

  state_t        state;
  logic [KW-1:0] k;
  logic [LW-1:0] s;
  logic [KW-1:0] m;
  logic          adv;
  logic          accept;
  logic          final_pair;

  logic          v1;
  logic          last1;
  logic [DW-1:0] re1;
  logic [DW-1:0] im1;
  logic [LW-1:0] s1;
  logic [KW-1:0] m1;

  // The whole pipeline advances unless the output bundle is being held.
  assign adv        = !(out_valid && !out_ready);
  assign in_ready   = (state == RUN) && adv;
  assign accept     = in_valid && in_ready;
  assign final_pair = (s == LW'(LW - 1)) && (k == {KW{1'b1}});
  assign done       = out_valid && out_ready && last;

  // k mod (N >> (s+1)) is a mask of the low KW-s bits since N is a power of two.
  assign m = (k & ({KW{1'b1}} >> s)) << s;

  // Transform framing FSM with stage/pair counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      k     <= '0;
      s     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            k     <= '0;
            s     <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            k <= k + KW'(1);
            if (k == {KW{1'b1}}) s <= s + LW'(1);
            if (final_pair) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage data pipeline; ROM output register forms stage 2 alongside out_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      last1     <= 1'b0;
      re1       <= '0;
      im1       <= '0;
      s1        <= '0;
      m1        <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      stage_idx <= '0;
      last      <= 1'b0;
    end else if (adv) begin
      v1        <= accept;
      last1     <= accept && final_pair;
      re1       <= in_re;
      im1       <= in_im;
      s1        <= s;
      m1        <= m;
      out_valid <= v1;
      out_re    <= re1;
      out_im    <= im1;
      stage_idx <= s1;
      last      <= v1 && last1;
    end
  end

  twiddle_rom #(
    .N    (N),
    .DW   (DW),
    .CONJ (CONJ)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .addr (m1),
    .w_r  (w_r),
    .w_i  (w_i)
  );

endmodule
